pulse_sync_fast_to_slow: RTL and testbench

Transfers single-cycle event pulses from the `clk_fast` domain to the `clk_slow` domain, where a raw pulse would be missed by the slower sampler. It uses a toggle request with a synchronized toggle acknowledge, and buffers one extra event while a transfer is in flight. Further events are dropped and counted. It sits on fast-to-slow control/event paths and complements the two-flop slow-to-fast level synchronizer.

---
 rtl/pulse_sync_fast_to_slow.sv | 137 +++++++++++++
 tb/tb_pulse_sync_fast_to_slow.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_sync_fast_to_slow.sv
// Fast-to-slow event pulse synchronizer: toggle request with a synchronized toggle
// acknowledge, a one-deep pending buffer and a saturating drop counter.
module pulse_sync_fast_to_slow #(
  parameter int SYNC_STAGES = 2,
  parameter int DROP_CNT_W  = 8
) (
  input  logic                  clk_fast,
  input  logic                  clk_slow,
  input  logic                  rst_n,
  input  logic                  pulse_in,
  input  logic                  drop_clr,
  output logic                  busy,
  output logic                  pending,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  pulse_out
);

  // Handshake: every flip of r_req_tog is one event. The slow side answers by making
  // r_ack_tog equal to r_req_tog. A transfer is complete once the synchronized
  // ack matches the request, and only then may r_req_tog flip again.
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Fast domain
  // ---------------------------------------------------------------------------
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_req_tog;
  logic                    w_req_tog_nxt;
  logic [SYNC_STAGES-1:0]  r_ack_sync;
  logic                    r_pending;
  logic                    w_pending_nxt;
  logic [DROP_CNT_W-1:0]   r_drop_cnt;
  logic                    w_drop_inc;
  logic                    w_done;

  // ---------------------------------------------------------------------------
  // Slow domain
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0]  r_req_sync;
  logic                    r_ack_tog;
  logic                    r_pulse_out;

  assign w_done = (r_ack_sync[SYNC_STAGES-1] == r_req_tog);

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_req_tog <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_req_tog <= w_req_tog_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_req_tog_nxt = r_req_tog;
    w_pending_nxt = r_pending;
    w_drop_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (pulse_in) begin
          w_req_tog_nxt = ~r_req_tog;
          w_state_nxt   = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (w_done) begin
          if (r_pending) begin
            // Launch the buffered event; a same-cycle event takes its slot.
            w_req_tog_nxt = ~r_req_tog;
            w_pending_nxt = pulse_in;
          end else if (pulse_in) begin
            w_req_tog_nxt = ~r_req_tog;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (pulse_in) begin
          if (r_pending) begin
            w_drop_inc = 1'b1;
          end else begin
            w_pending_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Clear has priority over a drop in the same cycle.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (drop_clr) begin
      r_drop_cnt <= '0;
    end else if (w_drop_inc && !(&r_drop_cnt)) begin
      r_drop_cnt <= r_drop_cnt + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Only stage 0 samples the slow-domain toggle.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], r_ack_tog};
    end
  end

  assign busy     = (r_state == ST_WAIT_ACK);
  assign pending  = r_pending;
  assign drop_cnt = r_drop_cnt;

  // Only stage 0 samples the fast-domain toggle; ack follows the synchronized request.
  always_ff @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) begin
      r_req_sync  <= '0;
      r_ack_tog   <= 1'b0;
      r_pulse_out <= 1'b0;
    end else begin
      r_req_sync  <= {r_req_sync[SYNC_STAGES-2:0], r_req_tog};
      r_ack_tog   <= r_req_sync[SYNC_STAGES-1];
      r_pulse_out <= r_req_sync[SYNC_STAGES-1] ^ r_ack_tog;
    end
  end

  assign pulse_out = r_pulse_out;

endmodule

// File: tb/tb_pulse_sync_fast_to_slow.sv
// Self-checking bench for pulse_sync_fast_to_slow: directed scenarios plus randomized
// bursts at three clock ratios, checked against a two-slot event buffer model.
`timescale 1ns/1ps
module tb_pulse_sync_fast_to_slow;

  localparam int SYNC_STAGES = 2;
  localparam int DROP_CNT_W  = 2;

  logic                  clk_fast = 1'b0;
  logic                  clk_slow = 1'b0;
  logic                  rst_n    = 1'b1;
  logic                  pulse_in = 1'b0;
  logic                  drop_clr = 1'b0;
  logic                  busy;
  logic                  pending;
  logic [DROP_CNT_W-1:0] drop_cnt;
  logic                  pulse_out;

  realtime fast_half = 5.0;
  realtime slow_half = 20.0;

  int n_tests   = 0;
  int n_fail    = 0;
  int pulse_cnt = 0;

  pulse_sync_fast_to_slow #(
    .SYNC_STAGES(SYNC_STAGES),
    .DROP_CNT_W (DROP_CNT_W)
  ) dut (
    .clk_fast (clk_fast),
    .clk_slow (clk_slow),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .drop_clr (drop_clr),
    .busy     (busy),
    .pending  (pending),
    .drop_cnt (drop_cnt),
    .pulse_out(pulse_out)
  );

  // ---------------- clock / reset ----------------
  initial forever #(fast_half) clk_fast = ~clk_fast;
  initial begin
    #3;
    forever #(slow_half) clk_slow = ~clk_slow;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  // Each pulse is one slow cycle wide, so each slow negedge with pulse_out high is one delivery.
  always @(negedge clk_slow) begin
    if (pulse_out) pulse_cnt <= pulse_cnt + 1;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic fast_cycle();
    @(posedge clk_fast);
    #1;
  endtask

  task automatic clear_drops();
    drop_clr = 1'b1;
    fast_cycle();
    drop_clr = 1'b0;
  endtask

  task automatic wait_not_busy(input string tag, input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      fast_cycle();
      n++;
    end
    check_eq(tag, busy, 0);
  endtask

  task automatic settle_slow(input int n);
    repeat (n) @(posedge clk_slow);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_single();
    int base;
    base = pulse_cnt;
    pulse_in = 1'b1;
    fast_cycle();                      // F0: req toggles here
    pulse_in = 1'b0;
    check_eq("single_busy", busy, 1);
    settle_slow(2);
    check_eq("single_early", pulse_out, 0);
    settle_slow(1);
    check_eq("single_rise3", pulse_out, 1);
    settle_slow(1);
    check_eq("single_width", pulse_out, 0);
    wait_not_busy("single_drain", 200);
    settle_slow(2);
    check_eq("single_count", pulse_cnt - base, 1);
  endtask

  task automatic test_pending();
    int base;
    clear_drops();
    base = pulse_cnt;
    pulse_in = 1'b1;
    fast_cycle();
    check_eq("pend_first", pending, 0);
    fast_cycle();
    check_eq("pend_second", pending, 1);
    check_eq("pend_nodrop", drop_cnt, 0);
    fast_cycle();
    pulse_in = 1'b0;
    check_eq("pend_third_drop", drop_cnt, 1);
    wait_not_busy("pend_drain", 400);
    settle_slow(2);
    check_eq("pend_count", pulse_cnt - base, 2);
    check_eq("pend_clear", pending, 0);
  endtask

  task automatic test_saturate();
    clear_drops();
    pulse_in = 1'b1;
    repeat (40) fast_cycle();
    check_eq("sat_value", drop_cnt, 3);
    drop_clr = 1'b1;                  // pulse_in still high: drops collide with clear
    fast_cycle();
    drop_clr = 1'b0;
    pulse_in = 1'b0;
    check_eq("sat_clear_wins", drop_cnt, 0);
    wait_not_busy("sat_drain", 400);
    settle_slow(3);
  endtask

  task automatic test_simultaneous();
    int base;
    int n;
    clear_drops();
    base = pulse_cnt;
    pulse_in = 1'b1;
    repeat (2) fast_cycle();
    pulse_in = 1'b0;
    check_eq("simul_pend", pending, 1);
    n = 0;
    while (pulse_out !== 1'b1 && n < 50) begin
      settle_slow(1);
      n++;
    end
    check_eq("simul_first_pulse", pulse_out, 1);
    // ack toggled on that slow edge: two fast edges to synchronize, completion on the third
    repeat (2) @(posedge clk_fast);
    #1;
    pulse_in = 1'b1;
    fast_cycle();
    pulse_in = 1'b0;
    check_eq("simul_pend_kept", pending, 1);
    check_eq("simul_no_drop", drop_cnt, 0);
    check_eq("simul_busy", busy, 1);
    wait_not_busy("simul_drain", 400);
    settle_slow(2);
    check_eq("simul_count", pulse_cnt - base, 3);
    check_eq("simul_drop_end", drop_cnt, 0);
  endtask

  task automatic test_reset_mid();
    int base;
    pulse_in = 1'b1;
    fast_cycle();
    pulse_in = 1'b0;
    settle_slow(1);                   // request reached the first sync stage only
    rst_n = 1'b0;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pending", pending, 0);
    check_eq("rst_drop", drop_cnt, 0);
    check_eq("rst_pulse", pulse_out, 0);
    #20;
    rst_n = 1'b1;
    base = pulse_cnt;
    settle_slow(20);
    check_eq("rst_no_spurious", pulse_cnt - base, 0);
    check_eq("rst_idle", busy, 0);
  endtask

  // Bursts of up to four consecutive cycles are shorter than the fastest possible
  // round trip, so the buffer model holds: first two events delivered, rest dropped.
  task automatic stress(input string name, input int bursts,
                        output int tot_in, output int tot_out, output int tot_drop);
    int base;
    int len;
    int events;
    int exp_acc;
    logic v;
    tot_in = 0; tot_out = 0; tot_drop = 0;
    for (int b = 0; b < bursts; b++) begin
      repeat ($urandom_range(0, 5)) fast_cycle();
      clear_drops();
      base   = pulse_cnt;
      len    = $urandom_range(1, 4);
      events = 0;
      for (int i = 0; i < len; i++) begin
        v = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        pulse_in = v;
        events += int'(v);
        fast_cycle();
      end
      pulse_in = 1'b0;
      wait_not_busy({name, "_drain"}, 500);
      settle_slow(3);
      exp_acc = (events > 2) ? 2 : events;
      check_eq({name, "_pulses"}, pulse_cnt - base, exp_acc);
      check_eq({name, "_drops"}, drop_cnt, events - exp_acc);
      tot_in   += events;
      tot_out  += pulse_cnt - base;
      tot_drop += int'(drop_cnt);
    end
    check_eq({name, "_balance"}, tot_out + tot_drop, tot_in);
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    int t_in, t_out, t_drop;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_pending", pending, 0);
    check_eq("reset_drop", drop_cnt, 0);
    check_eq("reset_pulse", pulse_out, 0);
    #49;
    rst_n = 1'b1;
    while ($realtime < 1000.0) @(posedge clk_fast);
    #1;

    test_single();
    test_pending();
    test_saturate();
    test_simultaneous();
    test_reset_mid();

    stress("r4to1", 20, t_in, t_out, t_drop);
    slow_half = 6.85;
    settle_slow(4);
    stress("r1p37", 20, t_in, t_out, t_drop);
    slow_half = 2.5;
    settle_slow(4);
    stress("r1to2", 20, t_in, t_out, t_drop);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
